// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order speculative store buffer with commit, flush and drain
//
// Holds generated stores until the ROB commits them, then drains committed
// stores in order to the data-memory write port.
//
// Optional feature macro: STB_LDFWD_EN (store-to-load forwarding lookup).
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   WE_AG, StrAddr_AG, store_data_AG,  allocate one store per cycle at tail
//   InstrNO_AG
//   stb_full, stb_empty                occupancy flags from registered pointers
//   commit_valid, commit_InstrNO       ROB retirement of the oldest uncommitted store
//   flush                              discard all uncommitted entries
//   mem_we, mem_addr, mem_wdata,       drain port, handshake on mem_ready
//   mem_ready
//   commit_err                         sticky illegal/mismatched commit flag
//   ld_addr, ld_hit, ld_data           forwarding lookup (tied off without macro)
module store_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE_AG,
    input  logic [31:0]      StrAddr_AG,
    input  logic [31:0]      store_data_AG,
    input  logic [TAG_W-1:0] InstrNO_AG,
    output logic             stb_full,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_InstrNO,
    input  logic             flush,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    output logic             commit_err,
    output logic             stb_empty,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [AW:0] ptr_t;   // index plus wrap bit

    ptr_t head;                   // oldest entry
    ptr_t cptr;                   // oldest uncommitted entry
    ptr_t tail;                   // next free slot

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];

    ptr_t count;
    logic commit_hit;
    logic commit_bad;
    logic alloc;
    logic pop;
    ptr_t cptr_nxt;

    assign count     = tail - head;
    assign stb_full  = (count == ptr_t'(DEPTH));
    assign stb_empty = (count == '0);

    assign commit_hit = commit_valid && (cptr != tail)
                        && (tag_q[cptr[AW-1:0]] == commit_InstrNO);
    assign commit_bad = commit_valid && !commit_hit;
    assign cptr_nxt   = commit_hit ? cptr + ptr_t'(1) : cptr;

    // Flush wins over allocate; a request while full is dropped.
    assign alloc = WE_AG && !stb_full && !flush;

    assign mem_we    = (head != cptr);
    // Gate the unreset storage so the drain port reads zero when idle.
    assign mem_addr  = mem_we ? addr_q[head[AW-1:0]] : '0;
    assign mem_wdata = mem_we ? data_q[head[AW-1:0]] : '0;
    assign pop       = mem_we && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            cptr       <= '0;
            tail       <= '0;
            commit_err <= 1'b0;
        end else begin
            if (pop)
                head <= head + ptr_t'(1);
            cptr <= cptr_nxt;
            // Commit resolves first, so the entry committed this cycle survives.
            if (flush)
                tail <= cptr_nxt;
            else if (alloc)
                tail <= tail + ptr_t'(1);
            if (commit_bad)
                commit_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail[AW-1:0]] <= StrAddr_AG;
            data_q[tail[AW-1:0]] <= store_data_AG;
            tag_q[tail[AW-1:0]]  <= InstrNO_AG;
        end
    end

`ifdef STB_LDFWD_EN
    logic [AW-1:0] fwd_idx;

    // Walk oldest to youngest so the last match is the youngest store.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head[AW-1:0] + AW'(i);
            if ((ptr_t'(i) < count) && (addr_q[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign ld_hit  = 1'b0;
    assign ld_data = '0;
`endif

endmodule

// File: doc/store_buffer.md
# store_buffer

In-order store buffer directly downstream of the store address-generation stage. Each cycle it accepts at most one generated store (address, data, instruction number) and holds it speculatively until the ROB commits that store. It then drains committed stores to the data-memory write port under a ready handshake. Uncommitted entries are discarded on a pipeline flush.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- TAG_W, 32, instruction-number width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- WE_AG  in  1  allocate request from address generation
- StrAddr_AG  in  32  store byte address
- store_data_AG  in  32  store data
- InstrNO_AG  in  TAG_W  instruction number of the store
- stb_full  out  1  no free entry; upstream must hold its store
- commit_valid  in  1  ROB retires a store this cycle
- commit_InstrNO  in  TAG_W  instruction number being retired
- flush  in  1  squash all uncommitted entries
- mem_we  out  1  write request to data memory
- mem_addr  out  32  write address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts the write this cycle
- commit_err  out  1  sticky: illegal or mismatched commit
- stb_empty  out  1  no valid entries
- ld_addr  in  32  load lookup address (STB_LDFWD_EN only)
- ld_hit  out  1  forwarding hit (STB_LDFWD_EN only)
- ld_data  out  32  forwarded data (STB_LDFWD_EN only)

## Operation
- Circular buffer with three log2(DEPTH)-bit pointers plus wrap bits: head (oldest), cptr (oldest uncommitted), tail (next free). Ordering head ≤ cptr ≤ tail, all modulo DEPTH.
- Allocate: WE_AG && !stb_full && !flush writes {addr, data, tag} at tail; tail advances. A request while stb_full is dropped; upstream must hold it.
- Commit: commit_valid with cptr≠tail and entry[cptr].tag == commit_InstrNO advances cptr. A tag mismatch, or commit_valid with cptr==tail, leaves state unchanged and sets commit_err. commit_err clears only on reset.
- Drain: mem_we = (head≠cptr). mem_addr/mem_wdata = entry[head]. mem_we && mem_ready advances head. Outputs are driven from registers and are stable while mem_ready is low.
- Flush: tail ← cptr, so all uncommitted entries are freed. Committed entries still drain.
- Simultaneous events in one cycle:
  - Commit is evaluated before flush, so the entry just committed survives.
  - Flush overrides allocate; the allocation is dropped.
  - Drain and allocate may both occur when not full.
  - Drain and commit may both occur.
- stb_full = count==DEPTH and stb_empty = count==0, where count = tail−head. Both come from registered pointers, so a slot freed by a pop is allocatable the next cycle, not the same cycle.

## Timing
- Reset (async assert, sync-safe release):
  - Pointers 0, commit_err 0, entry storage don't-care.
  - Outputs: mem_we 0, stb_full 0, stb_empty 1, ld_hit 0, mem_addr/mem_wdata/ld_data 0.
- Reset mid-drain drops all entries, including committed ones, and mem_we falls immediately.
- Allocate → earliest commit: the next cycle.
- Commit → mem_we: asserted the cycle after commit, i.e. 1-cycle latency.
- Back-to-back drain at one store per cycle while mem_ready stays high.
- Pointer wrap: after DEPTH allocations, tail returns to 0 with its wrap bit toggled. full/empty are distinguished by the wrap bit.

## Configuration
- STB_LDFWD_EN defined:
  - Combinational lookup across all valid entries (head..tail, committed and uncommitted).
  - ld_hit=1 when any entry has addr == ld_addr. ld_data comes from the youngest matching entry.
  - The lookup does not see an entry being allocated in the same cycle.
- Not defined: ld_addr is ignored, and ld_hit and ld_data are tied to 0.

## Test plan
- Reset, 3 stores, 3 commits:
  - Stimulus: reset; allocate 0x100/0xAAAA0001 (tag 5), 0x104/0x…02 (tag 6), 0x108/0x…03 (tag 7); commit 5, 6, 7; mem_ready=1.
  - Required: mem_we first rises the cycle after commit 5. Writes appear in tag order 5, 6, 7, then stb_empty=1.
- Fill and stall:
  - Stimulus: 8 allocations without commit.
  - Required: stb_full=1. A 9th WE_AG is not stored (tail unchanged). One commit plus one drain clears stb_full the cycle after the pop.
- Flush:
  - Stimulus: 4 entries, 2 committed, mem_ready=0; assert flush.
  - Required: count becomes 2. When mem_ready is raised, only the 2 committed stores drain.
- Commit errors:
  - Stimulus: commit_InstrNO=9 while the oldest uncommitted tag is 8; separately, commit_valid with no uncommitted entry.
  - Required: cptr does not move and commit_err=1, staying high until rst_n=0.
- Forwarding (STB_LDFWD_EN):
  - Stimulus: stores to 0x200 with 0x11 then 0x22; ld_addr=0x200.
  - Required: ld_hit=1, ld_data=0x22. With ld_addr=0x204, ld_hit=0. Without the macro, ld_hit=0 always.
- Wrap and mid-drain reset:
  - Stimulus: 20 allocate/commit/drain iterations.
  - Required: data matches at every pointer wrap. Asserting rst_n low during mem_we=1 makes mem_we 0 immediately and stb_empty=1.
